// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory request/acknowledge bus between the fetch front end and
// the instruction memory.
//
// Signals:
//   imem_req   - request outstanding (fetch -> memory), held until ack
//   imem_addr  - word address of the outstanding request (fetch -> memory)
//   imem_ack   - memory returns imem_rdata this cycle (memory -> fetch)
//   imem_rdata - instruction word (memory -> fetch)
//
// Modports:
//   master - fetch side (drives req/addr)
//   slave  - memory side (drives ack/rdata)
interface pc_fetch_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Instruction-fetch front end of the MIPS pipeline.
//
// Owns the fetch PC, selects the next PC (sequential +4, ID-stage jump,
// EX-stage taken branch), runs the single-outstanding instruction-memory
// handshake and buffers returned words in a 2-entry queue whose head feeds
// the IF/ID register. Redirects generate flush strobes for IF/ID and ID/EX.
//
// Ports:
//   clk, rst         - rising-edge clock, asynchronous active-high reset
//   stall            - IF/ID holds this cycle (no pop, jumps ignored)
//   br_taken/target  - EX-stage taken branch and its target (wins over jump)
//   jmp_valid/target - ID-stage jump/jr and its target
//   imem             - instruction-memory bus (master side)
//   if_valid/instr/pc/pc_plus4 - registered queue head presented to IF/ID
//   flush_ifid       - redirect this cycle (combinational)
//   flush_idex       - branch redirect this cycle (combinational)
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  br_taken,
    input  logic [31:0]           br_target,
    input  logic                  jmp_valid,
    input  logic [31:0]           jmp_target,
    pc_fetch_ctrl_if.master       imem,
    output logic                  if_valid,
    output logic [31:0]           if_instr,
    output logic [31:0]           if_pc,
    output logic [31:0]           if_pc_plus4,
    output logic                  flush_ifid,
    output logic                  flush_idex
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_KILL = 2'd2;

    localparam logic [31:0] RESET_ADDR = RESET_PC & ~32'd3;

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic [1:0]  count;
    logic [1:0]  count_next;
    logic [31:0] fetch_pc;
    logic [31:0] req_addr;
    logic [31:0] head_pc;
    logic [31:0] head_instr;
    logic [31:0] tail_pc;
    logic [31:0] tail_instr;

    logic        redir;
    logic [31:0] target;
    logic        push;
    logic        pop;
    logic        pending_after;
    logic        issue;

    always_comb begin
        redir  = br_taken | (jmp_valid & ~stall);
        target = br_taken ? br_target : jmp_target;

        // A word returned for a killed request, or on a redirect edge, is dropped.
        push = (state == ST_BUSY) & imem.imem_ack & ~redir;
        pop  = (count != 2'd0) & ~stall & ~redir;

        if (redir) begin
            count_next = 2'd0;
        end else begin
            count_next = count + {1'b0, push} - {1'b0, pop};
        end

        // Request still in flight after this edge (not yet acknowledged).
        pending_after = (state != ST_IDLE) & ~imem.imem_ack;

        // A new request must fit in the queue alongside everything already
        // buffered, so queued + outstanding never exceeds two words.
        issue = ~redir & ~pending_after & (count_next <= 2'd1);

        state_next = ST_IDLE;
        if (issue) begin
            state_next = ST_BUSY;
        end else if (pending_after) begin
            // An unacknowledged request cannot be withdrawn; remember to drop its data.
            state_next = (redir && (state == ST_BUSY)) ? ST_KILL : state;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            count      <= 2'd0;
            fetch_pc   <= RESET_ADDR;
            req_addr   <= RESET_PC;
            head_pc    <= 32'd0;
            head_instr <= 32'd0;
            tail_pc    <= 32'd0;
            tail_instr <= 32'd0;
        end else begin
            state <= state_next;
            count <= count_next;

            if (redir) begin
                fetch_pc <= target & ~32'd3;
            end else if (issue) begin
                fetch_pc <= fetch_pc + 32'd4;
            end

            if (issue) begin
                req_addr <= fetch_pc;
            end

            // Queue shift: head always holds the oldest word.
            if (pop) begin
                if (push && (count == 2'd1)) begin
                    head_pc    <= req_addr;
                    head_instr <= imem.imem_rdata;
                end else begin
                    head_pc    <= tail_pc;
                    head_instr <= tail_instr;
                end
                if (push && (count == 2'd2)) begin
                    tail_pc    <= req_addr;
                    tail_instr <= imem.imem_rdata;
                end
            end else if (push) begin
                if (count == 2'd0) begin
                    head_pc    <= req_addr;
                    head_instr <= imem.imem_rdata;
                end else begin
                    tail_pc    <= req_addr;
                    tail_instr <= imem.imem_rdata;
                end
            end
        end
    end

    assign imem.imem_req  = (state != ST_IDLE);
    assign imem.imem_addr = req_addr;

    assign if_valid    = (count != 2'd0);
    assign if_instr    = head_instr;
    assign if_pc       = head_pc;
    assign if_pc_plus4 = head_pc + 32'd4;

    assign flush_ifid = redir;
    assign flush_idex = br_taken;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Testbench for pc_fetch_ctrl: memory responder with programmable latency,
// address predictor and fetch-queue scoreboard, plus directed scenarios.
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = 32'd0;
    logic        jmp_valid = 1'b0;
    logic [31:0] jmp_target = 32'd0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        flush_ifid;
    logic        flush_idex;

    pc_fetch_ctrl_if bus();

    pc_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .jmp_valid   (jmp_valid),
        .jmp_target  (jmp_target),
        .imem        (bus),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_pc_plus4 (if_pc_plus4),
        .flush_ifid  (flush_ifid),
        .flush_idex  (flush_idex)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int mem_lat  = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t sb_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        stall = 1'b0; br_taken = 1'b0; jmp_valid = 1'b0;
        br_target = 32'd0; jmp_target = 32'd0;
        mem_lat = 0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Memory responder + scoreboard, evaluated on the falling edge.
    int          wait_cnt = 0;
    logic        killed = 1'b0;
    logic        prev_req = 1'b0;
    logic        prev_ack = 1'b0;
    logic [31:0] prev_addr = 32'd0;
    logic [31:0] pred_addr = 32'd0;
    logic [31:0] cur_addr = 32'd0;
    logic        redir_m;
    entry_t      new_e;

    initial begin
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bus.imem_ack   = 1'b0;
                bus.imem_rdata = 32'd0;
                wait_cnt  = 0;
                killed    = 1'b0;
                prev_req  = 1'b0;
                prev_ack  = 1'b0;
                pred_addr = 32'd0;
                sb_q.delete();
            end else begin
                if (bus.imem_req === 1'b1) begin
                    if (wait_cnt >= mem_lat) begin
                        bus.imem_ack   = 1'b1;
                        bus.imem_rdata = mem_word(bus.imem_addr);
                        wait_cnt = 0;
                    end else begin
                        bus.imem_ack = 1'b0;
                        wait_cnt++;
                    end
                end else begin
                    bus.imem_ack = 1'b0;
                    wait_cnt = 0;
                end

                if (prev_req && !prev_ack) begin
                    n_assert++;
                    if (bus.imem_req !== 1'b1 || bus.imem_addr !== prev_addr) begin
                        n_fail++;
                        $display("FAIL req_hold: req=%b addr=%h, required req=1 addr=%h", bus.imem_req, bus.imem_addr, prev_addr);
                    end
                end

                if (bus.imem_req === 1'b1 && (!prev_req || prev_ack)) begin
                    n_assert++;
                    if (bus.imem_addr !== pred_addr) begin
                        n_fail++;
                        $display("FAIL req_addr: got %h, required %h", bus.imem_addr, pred_addr);
                    end
                    cur_addr  = pred_addr;
                    pred_addr = pred_addr + 32'd4;
                end

                redir_m = br_taken | (jmp_valid & ~stall);

                n_assert++;
                if (flush_ifid !== redir_m) begin
                    n_fail++;
                    $display("FAIL flush_ifid: got %b, required %b", flush_ifid, redir_m);
                end
                n_assert++;
                if (flush_idex !== br_taken) begin
                    n_fail++;
                    $display("FAIL flush_idex: got %b, required %b", flush_idex, br_taken);
                end
                n_assert++;
                if (if_valid !== (sb_q.size() != 0)) begin
                    n_fail++;
                    $display("FAIL if_valid: got %b, required %b", if_valid, (sb_q.size() != 0));
                end
                if (sb_q.size() != 0) begin
                    n_assert++;
                    if (if_pc !== sb_q[0].pc || if_instr !== sb_q[0].instr ||
                        if_pc_plus4 !== sb_q[0].pc + 32'd4) begin
                        n_fail++;
                        $display("FAIL queue_head: got pc=%h instr=%h pc4=%h, required pc=%h instr=%h pc4=%h",
                                 if_pc, if_instr, if_pc_plus4, sb_q[0].pc, sb_q[0].instr, sb_q[0].pc + 32'd4);
                    end
                end
                if (bus.imem_ack === 1'b1) begin
                    n_assert++;
                    if (sb_q.size() == 2) begin
                        n_fail++;
                        $display("FAIL ack_full: ack with queue count %0d, required below 2", sb_q.size());
                    end
                end

                // Effects of the coming rising edge on the reference model.
                if (redir_m) begin
                    sb_q.delete();
                    pred_addr = (br_taken ? br_target : jmp_target) & ~32'd3;
                    killed = (bus.imem_req === 1'b1) && (bus.imem_ack !== 1'b1);
                end else begin
                    if (sb_q.size() != 0 && !stall) begin
                        void'(sb_q.pop_front());
                    end
                    if (bus.imem_ack === 1'b1) begin
                        if (!killed) begin
                            new_e.pc    = cur_addr;
                            new_e.instr = mem_word(cur_addr);
                            sb_q.push_back(new_e);
                        end
                        killed = 1'b0;
                    end
                end

                prev_req  = (bus.imem_req === 1'b1);
                prev_ack  = (bus.imem_ack === 1'b1);
                prev_addr = bus.imem_addr;
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        tick();
        n_assert++;
        if (bus.imem_req !== 1'b0 || bus.imem_addr !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_imem: got req=%b addr=%h, required req=0 addr=0", bus.imem_req, bus.imem_addr);
        end
        n_assert++;
        if (if_valid !== 1'b0 || if_instr !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_if: got valid=%b instr=%h, required 0/0", if_valid, if_instr);
        end
        n_assert++;
        if (if_pc !== 32'd0 || if_pc_plus4 !== 32'd4) begin
            n_fail++;
            $display("FAIL reset_pc: got pc=%h pc4=%h, required 0/4", if_pc, if_pc_plus4);
        end
        br_taken = 1'b1;
        #1;
        n_assert++;
        if (flush_ifid !== 1'b1 || flush_idex !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_flush_br: got %b%b, required 11", flush_ifid, flush_idex);
        end
        br_taken = 1'b0;
        jmp_valid = 1'b1;
        #1;
        n_assert++;
        if (flush_ifid !== 1'b1 || flush_idex !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flush_jmp: got %b%b, required 10", flush_ifid, flush_idex);
        end
        jmp_valid = 1'b0;
    endtask

    task automatic test_sequential();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick();
            n_assert++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'(4 * i)) begin
                n_fail++;
                $display("FAIL seq_addr[%0d]: got req=%b addr=%h, required req=1 addr=%h", i, bus.imem_req, bus.imem_addr, 32'(4 * i));
            end
            n_assert++;
            if (i == 0) begin
                if (if_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL seq_first_valid: got %b, required 0", if_valid);
                end
            end else if (if_valid !== 1'b1 || if_pc !== 32'(4 * (i - 1)) || if_pc_plus4 !== 32'(4 * i)) begin
                n_fail++;
                $display("FAIL seq_if[%0d]: got v=%b pc=%h pc4=%h, required v=1 pc=%h pc4=%h",
                         i, if_valid, if_pc, if_pc_plus4, 32'(4 * (i - 1)), 32'(4 * i));
            end
        end
    endtask

    task automatic test_stall();
        int k;
        do_reset();
        k = 0;
        while (k < 20 && !(if_valid === 1'b1 && if_pc === 32'h10)) begin
            tick();
            k++;
        end
        n_assert++;
        if (k >= 20) begin
            n_fail++;
            $display("FAIL stall_wait: head 0x10 not seen, if_pc=%h required 00000010", if_pc);
        end
        stall = 1'b1;
        #1;
        n_assert++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h14) begin
            n_fail++;
            $display("FAIL stall_pending: got req=%b addr=%h, required 1/00000014", bus.imem_req, bus.imem_addr);
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            n_assert++;
            if (bus.imem_req !== 1'b0 || if_valid !== 1'b1 || if_pc !== 32'h10) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got req=%b v=%b pc=%h, required 0/1/00000010", c, bus.imem_req, if_valid, if_pc);
            end
        end
        stall = 1'b0;
        tick();
        n_assert++;
        if (if_pc !== 32'h14 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h18) begin
            n_fail++;
            $display("FAIL stall_release: got pc=%h req=%b addr=%h, required 00000014/1/00000018", if_pc, bus.imem_req, bus.imem_addr);
        end
        tick();
        n_assert++;
        if (if_pc !== 32'h18) begin
            n_fail++;
            $display("FAIL stall_order: got pc=%h, required 00000018", if_pc);
        end
    endtask

    task automatic test_branch();
        int k;
        do_reset();
        k = 0;
        while (k < 30 && !(bus.imem_req === 1'b1 && bus.imem_addr === 32'h20)) begin
            tick();
            k++;
        end
        n_assert++;
        if (k >= 30) begin
            n_fail++;
            $display("FAIL br_wait: request 0x20 not seen, addr=%h", bus.imem_addr);
        end
        mem_lat = 3;
        br_taken = 1'b1;
        br_target = 32'h400;
        #1;
        n_assert++;
        if (flush_ifid !== 1'b1 || flush_idex !== 1'b1) begin
            n_fail++;
            $display("FAIL br_flush: got %b%b, required 11", flush_ifid, flush_idex);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            br_taken = 1'b0;
            n_assert++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h20 || if_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL br_kill[%0d]: got req=%b addr=%h v=%b, required 1/00000020/0", c, bus.imem_req, bus.imem_addr, if_valid);
            end
        end
        tick();
        mem_lat = 0;
        n_assert++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h400) begin
            n_fail++;
            $display("FAIL br_target: got req=%b addr=%h, required 1/00000400", bus.imem_req, bus.imem_addr);
        end
        tick();
        n_assert++;
        if (if_valid !== 1'b1 || if_pc !== 32'h400 || if_instr !== mem_word(32'h400)) begin
            n_fail++;
            $display("FAIL br_word: got v=%b pc=%h instr=%h, required 1/00000400/%h", if_valid, if_pc, if_instr, mem_word(32'h400));
        end
    endtask

    task automatic test_br_jmp();
        do_reset();
        for (int c = 0; c < 4; c++) tick();
        br_taken = 1'b1; br_target = 32'h100;
        jmp_valid = 1'b1; jmp_target = 32'h200;
        #1;
        n_assert++;
        if (flush_ifid !== 1'b1 || flush_idex !== 1'b1) begin
            n_fail++;
            $display("FAIL brjmp_flush: got %b%b, required 11", flush_ifid, flush_idex);
        end
        tick();
        br_taken = 1'b0; jmp_valid = 1'b0;
        n_assert++;
        if (bus.imem_req !== 1'b0 || if_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL brjmp_idle: got req=%b v=%b, required 0/0", bus.imem_req, if_valid);
        end
        tick();
        n_assert++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL brjmp_target: got req=%b addr=%h, required 1/00000100", bus.imem_req, bus.imem_addr);
        end
        stall = 1'b1;
        jmp_valid = 1'b1; jmp_target = 32'h200;
        #1;
        n_assert++;
        if (flush_ifid !== 1'b0 || flush_idex !== 1'b0) begin
            n_fail++;
            $display("FAIL jmp_stall_flush: got %b%b, required 00", flush_ifid, flush_idex);
        end
        tick();
        jmp_valid = 1'b0; stall = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        n_assert++;
        if (bus.imem_req !== 1'b1 || (bus.imem_addr & 32'hFFFF_FF00) !== 32'h100) begin
            n_fail++;
            $display("FAIL jmp_stall_ignored: got req=%b addr=%h, required 1/000001xx", bus.imem_req, bus.imem_addr);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] wrap_addr [3];
        wrap_addr[0] = 32'hFFFF_FFF8;
        wrap_addr[1] = 32'hFFFF_FFFC;
        wrap_addr[2] = 32'h0000_0000;
        do_reset();
        tick();
        tick();
        jmp_valid = 1'b1; jmp_target = 32'hFFFF_FFF8;
        tick();
        jmp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_assert++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== wrap_addr[i]) begin
                n_fail++;
                $display("FAIL wrap_addr[%0d]: got req=%b addr=%h, required 1/%h", i, bus.imem_req, bus.imem_addr, wrap_addr[i]);
            end
        end
        n_assert++;
        if (if_pc !== 32'hFFFF_FFFC || if_pc_plus4 !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_pc4: got pc=%h pc4=%h, required FFFFFFFC/00000000", if_pc, if_pc_plus4);
        end
        jmp_valid = 1'b1; jmp_target = 32'h403;
        tick();
        jmp_valid = 1'b0;
        tick();
        n_assert++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h400) begin
            n_fail++;
            $display("FAIL align_target: got req=%b addr=%h, required 1/00000400", bus.imem_req, bus.imem_addr);
        end
    endtask

    task automatic test_rst_mid();
        do_reset();
        for (int c = 0; c < 5; c++) tick();
        mem_lat = 2;
        stall = 1'b1;
        tick();
        tick();
        n_assert++;
        if (if_valid !== 1'b1 || bus.imem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_pre: got v=%b req=%b, required 1/1", if_valid, bus.imem_req);
        end
        #2;
        rst = 1'b1;
        #1;
        n_assert++;
        if (bus.imem_req !== 1'b0 || bus.imem_addr !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_mid_imem: got req=%b addr=%h, required 0/00000000", bus.imem_req, bus.imem_addr);
        end
        n_assert++;
        if (if_valid !== 1'b0 || if_pc !== 32'd0 || if_pc_plus4 !== 32'd4 || if_instr !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_mid_if: got v=%b pc=%h pc4=%h instr=%h, required 0/0/4/0", if_valid, if_pc, if_pc_plus4, if_instr);
        end
        stall = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        mem_lat = 0;
        tick();
        n_assert++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_mid_restart: got req=%b addr=%h, required 1/00000000", bus.imem_req, bus.imem_addr);
        end
        tick();
        n_assert++;
        if (if_valid !== 1'b1 || if_pc !== 32'd0 || if_instr !== mem_word(32'd0)) begin
            n_fail++;
            $display("FAIL rst_mid_word: got v=%b pc=%h instr=%h, required 1/00000000/%h", if_valid, if_pc, if_instr, mem_word(32'd0));
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_br_jmp();
        test_wrap();
        test_rst_mid();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Instruction-fetch front end of the MIPS pipeline. It owns the fetch PC, resolves next-PC selection (sequential PC+4, ID-stage jump, EX-stage taken branch) and drives the instruction-memory request/acknowledge handshake. Fetched words are held in a 2-entry fetch queue that feeds the IF/ID register. On every redirect it generates the flush strobes for IF/ID and ID/EX.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-high
- stall  in  1  hazard-unit hold; IF/ID does not accept a word this cycle
- br_taken  in  1  EX-stage branch resolved taken
- br_target  in  32  branch target
- jmp_valid  in  1  ID-stage jump/jr decoded
- jmp_target  in  32  jump target
- imem_req  out  1  request outstanding to instruction memory
- imem_addr  out  32  word address of the outstanding request
- imem_ack  in  1  memory returns imem_rdata this cycle
- imem_rdata  in  32  instruction word
- if_valid  out  1  queue head valid
- if_instr  out  32  queue head instruction
- if_pc  out  32  address of queue head
- if_pc_plus4  out  32  if_pc + 4 (link value / sequential input of the PC select path)
- flush_ifid  out  1  kill IF/ID contents this edge
- flush_idex  out  1  kill ID/EX contents this edge

## Operation
- State: fetch_pc (next address to request), req state {IDLE, BUSY, KILL}, req_addr, queue (2 entries, count 0..2), outstanding flag (max 1).
- Redirect event: redir = br_taken | (jmp_valid & ~stall). Target = br_target if br_taken, else jmp_target. Branch wins over jump in the same cycle. Jump is ignored while stall=1. Branch overrides stall.
- flush_ifid = redir, flush_idex = br_taken; both combinational, same cycle.
- Redirect edge: fetch_pc <= target; queue count <= 0; BUSY without ack -> KILL; BUSY with ack -> IDLE, data discarded; KILL stays KILL (latest target kept).
- Consume: head popped on an edge when if_valid=1, stall=0, redir=0.
- Ack in BUSY (no redirect): push {imem_rdata, req_addr}. Ack in KILL: data dropped -> IDLE.
- Issue rule: a request is issued on an edge only if, after that edge, queue count + outstanding <= 2 and no redirect occurs that edge. Issue sets req_addr <= fetch_pc, fetch_pc <= fetch_pc + 4, state BUSY. Issue is allowed on the ack edge (back-to-back).
- The first issue after a redirect uses the new target, no earlier than the edge after the redirect.
- Targets used as-is; bits [1:0] forced to 0 on imem_addr and fetch_pc.
- All PC arithmetic modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.

## Timing
- Reset (async, immediate): imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0, if_pc_plus4=4, queue empty, state IDLE, fetch_pc=RESET_PC. flush_* follow inputs.
- Edge 1 after rst deasserts: first issue. imem_req rises with imem_addr=RESET_PC.
- imem_req and imem_addr are registered and held stable until the ack cycle. The request is never withdrawn before ack, including in KILL.
- imem_req stays high across back-to-back issues; imem_addr changes on the edge after ack.
- Ack may arrive in the first cycle imem_req is high. With zero-wait memory and no stalls, throughput is 1 word/cycle.
- Pushed word is visible on if_* the cycle after its ack edge. if_* is registered from the queue head.
- Push and pop on the same edge with count=2 is legal: count stays 2.
- Ack while count=2 cannot occur by the issue rule. The bench asserts this never happens.
- rst mid-request: imem_req drops immediately, the in-flight ack is ignored, fetch restarts at RESET_PC.

## Test plan
- Reset release, zero-wait memory, stall=0 -> imem_addr 0,4,8,C on consecutive cycles; if_pc 0,4,8 one cycle after each ack; if_pc_plus4 = if_pc+4.
- stall=1 for 5 cycles with 1-cycle ack -> queue fills to 2, imem_req low after the second ack; if_pc held at 0x10. Stall release -> words pop in order, issue resumes at 0x18.
- br_taken=1, br_target=0x400 while a request to 0x20 is outstanding and acked 3 cycles later -> flush_ifid=flush_idex=1 for that cycle; the 0x20 word is discarded; the next imem_addr is 0x400.
- br_taken and jmp_valid in the same cycle (targets 0x100/0x200) -> fetch resumes at 0x100, flush_idex=1. jmp_valid with stall=1 -> no flush, no redirect.
- fetch_pc=0xFFFF_FFF8, sequential fetch -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000. Target 0x403 -> imem_addr 0x400.
- rst pulse during BUSY with ack pending -> outputs at reset values immediately; the next fetch is RESET_PC; the late ack is not pushed.
